// File: rtl/ram_copy_master.sv
// ram_copy_master: copies len_i consecutive 32-bit words from src_addr_i to
// dst_addr_i over a single-port memory bus, one word at a time
// (READ -> WAIT -> WRITE), with at most one request outstanding.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               one-cycle copy request, accepted only when idle
//   src_addr_i/dst_addr_i byte addresses of first source/destination word
//   len_i                 number of words to copy
//   busy_o, done_o        copy in progress / one-cycle end-of-copy pulse
//   error_o               sticky read-timeout flag, cleared by next start
//   count_o               words written in the current or last copy
//   req_o, we_o, be_o     memory request, write enable, byte enables
//   addr_o, wdata_o       memory byte address and write data
//   rvalid_i, rdata_i     read response from the memory
module ram_copy_master #(
    parameter int LenW    = 16,
    parameter int Timeout = 15
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [31:0]     src_addr_i,
    input  logic [31:0]     dst_addr_i,
    input  logic [LenW-1:0] len_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            error_o,
    output logic [LenW-1:0] count_o,
    output logic            req_o,
    output logic            we_o,
    output logic [3:0]      be_o,
    output logic [31:0]     addr_o,
    output logic [31:0]     wdata_o,
    input  logic            rvalid_i,
    input  logic [31:0]     rdata_i
);

    localparam int TmoW = $clog2(Timeout + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_e;

    state_e            state_q;
    logic [29:0]       src_q, dst_q;     // word addresses; wrap mod 2^32 bytes
    logic [29:0]       src_d, dst_d;
    logic [LenW-1:0]   len_q;
    logic [LenW-1:0]   count_q, count_d;
    logic [TmoW-1:0]   tmo_q;
    logic              req_q, we_q, busy_q, done_q, error_q;
    logic [3:0]        be_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;           // doubles as the read-data buffer

    // Byte-offset bits of the addresses are deliberately dropped.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{src_addr_i[1:0], dst_addr_i[1:0]};

    assign src_d   = src_q + 30'd1;
    assign dst_d   = dst_q + 30'd1;
    assign count_d = count_q + LenW'(1);

    // Latched copy parameters: no reset, never visible on the outputs in IDLE.
    always_ff @(posedge clk_i) begin
        if (state_q == S_IDLE && start_i) begin
            src_q <= src_addr_i[31:2];
            dst_q <= dst_addr_i[31:2];
            len_q <= len_i;
        end else if (state_q == S_WRITE) begin
            src_q <= src_d;
            dst_q <= dst_d;
        end
    end

    // Control FSM. Bus outputs are registered: each transition loads the
    // values the destination state must present, and they default back to 0
    // so the bus is quiet whenever req_o is low.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            count_q <= '0;
            tmo_q   <= '0;
        end else begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            done_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        count_q <= '0;
                        error_q <= 1'b0;
                        busy_q  <= 1'b1;
                        tmo_q   <= '0;
                        if (len_i == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_READ;
                            req_q   <= 1'b1;
                            addr_q  <= {src_addr_i[31:2], 2'b00};
                        end
                    end
                end
                S_READ: begin
                    state_q <= S_WAIT;
                    tmo_q   <= '0;
                end
                S_WAIT: begin
                    if (rvalid_i) begin
                        state_q <= S_WRITE;
                        req_q   <= 1'b1;
                        we_q    <= 1'b1;
                        be_q    <= 4'hF;
                        addr_q  <= {dst_q, 2'b00};
                        wdata_q <= rdata_i;
                    end else if (tmo_q == TmoW'(Timeout - 1)) begin
                        // Last permitted WAIT cycle passed without data.
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        error_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TmoW'(1);
                    end
                end
                S_WRITE: begin
                    count_q <= count_d;
                    if (count_d == len_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_READ;
                        req_q   <= 1'b1;
                        addr_q  <= {src_d, 2'b00};
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign error_o = error_q;
    assign count_o = count_q;
    assign req_o   = req_q;
    assign we_o    = we_q;
    assign be_o    = be_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;

endmodule

// File: tb/tb_ram_copy_master.sv
// Self-checking bench for ram_copy_master: a single-port RAM responder,
// a table of directed copies, randomized copies and a reset-mid-copy sequence.
module tb_ram_copy_master;

    localparam int TMO = 15;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] src_addr_i = '0;
    logic [31:0] dst_addr_i = '0;
    logic [15:0] len_i = '0;
    logic        busy_o, done_o, error_o;
    logic [15:0] count_o;
    logic        req_o, we_o;
    logic [3:0]  be_o;
    logic [31:0] addr_o, wdata_o;
    logic        rvalid_i = 1'b0;
    logic [31:0] rdata_i = '0;

    ram_copy_master #(.LenW(16), .Timeout(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .count_o(count_o),
        .req_o(req_o), .we_o(we_o), .be_o(be_o), .addr_o(addr_o), .wdata_o(wdata_o),
        .rvalid_i(rvalid_i), .rdata_i(rdata_i)
    );

    initial forever #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- memory contents ----------------
    logic [31:0] seed = 32'h1234_5678;
    logic [31:0] tm [logic [29:0]];   // responder RAM (written words)
    logic [31:0] mm [logic [29:0]];   // reference model RAM

    function automatic logic [31:0] pat(input logic [29:0] a);
        return ({a, 2'b00} * 32'h9E37_79B1) ^ seed;
    endfunction
    function automatic logic [31:0] tm_rd(input logic [29:0] a);
        if (tm.exists(a)) return tm[a];
        return pat(a);
    endfunction
    function automatic logic [31:0] mm_rd(input logic [29:0] a);
        if (mm.exists(a)) return mm[a];
        return pat(a);
    endfunction

    // ---------------- bus monitor and responder ----------------
    logic [31:0] got_rd[$];
    logic [31:0] got_wa[$];
    logic [31:0] got_wd[$];
    int          rd_idx = 0;
    int          stall_rd = -1;
    int          inv_bad = 0;
    int          req_total = 0;
    logic        pend_v = 1'b0;
    logic [31:0] pend_d = '0;

    initial forever begin
        @(negedge clk_i);
        if (req_o) begin
            req_total++;
            if (we_o) begin
                got_wa.push_back(addr_o);
                got_wd.push_back(wdata_o);
                tm[addr_o[31:2]] = wdata_o;
                if (be_o != 4'hF) inv_bad++;
                pend_v = 1'b1;               // responder also answers writes
                pend_d = 32'hDEAD_BEEF;
            end else begin
                got_rd.push_back(addr_o);
                if (be_o != 4'h0) inv_bad++;
                pend_v = (rd_idx != stall_rd);
                pend_d = tm_rd(addr_o[31:2]);
                rd_idx++;
            end
        end else begin
            if (addr_o != 0 || wdata_o != 0 || we_o || be_o != 0) inv_bad++;
            pend_v = 1'b0;
        end
    end

    initial forever begin
        @(posedge clk_i);
        #1;
        rvalid_i = pend_v;
        rdata_i  = pend_v ? pend_d : 32'h0;
    end

    // ---------------- one copy, checked against the model ----------------
    task automatic run_copy(input string nm, input logic [31:0] src, input logic [31:0] dst,
                            input int len, input int stall, input bit extra,
                            input int exp_count, input bit exp_err, input int exp_done);
        logic [31:0] exp_rd[$];
        logic [31:0] exp_wa[$];
        logic [31:0] exp_wd[$];
        logic [31:0] ra, wa, d;
        int n, done_n, done_cnt;

        tm.delete();
        mm.delete();
        seed = $urandom;
        // Model: word-by-word forward copy from aligned byte addresses.
        for (int i = 0; i < len; i++) begin
            ra = (src & ~32'h3) + 32'(4 * i);
            exp_rd.push_back(ra);
            if (i == stall) break;
            d  = mm_rd(ra[31:2]);
            wa = (dst & ~32'h3) + 32'(4 * i);
            exp_wa.push_back(wa);
            exp_wd.push_back(d);
            mm[wa[31:2]] = d;
        end

        @(posedge clk_i);
        #1;
        got_rd.delete();
        got_wa.delete();
        got_wd.delete();
        rd_idx = 0;
        stall_rd = stall;
        inv_bad = 0;
        src_addr_i = src;
        dst_addr_i = dst;
        len_i = 16'(len);
        start_i = 1'b1;

        n = 0;
        done_n = -1;
        done_cnt = 0;
        while (n < 200 && (done_n < 0 || n < done_n + 3)) begin
            @(posedge clk_i);
            #1;
            n++;
            if (n == 1) begin
                start_i = 1'b0;
                check({nm, ".busy_on"}, 64'(busy_o), 64'd1);
                check({nm, ".err_clr"}, 64'(error_o), 64'd0);
            end
            if (extra && n == 2) begin
                start_i = 1'b1;
                src_addr_i = 32'h0000_ABC0;
                dst_addr_i = 32'h0000_DEF0;
                len_i = 16'd7;
            end
            if (extra && n == 3) start_i = 1'b0;
            if (done_o) begin
                done_cnt++;
                if (done_n < 0) done_n = n;
            end
        end

        check({nm, ".done_at"}, 64'(done_n), 64'(exp_done));
        check({nm, ".done_cnt"}, 64'(done_cnt), 64'd1);
        check({nm, ".count"}, 64'(count_o), 64'(exp_count));
        check({nm, ".error"}, 64'(error_o), 64'(exp_err));
        check({nm, ".busy_off"}, 64'(busy_o), 64'd0);
        check({nm, ".bus_quiet"}, 64'(inv_bad), 64'd0);
        check({nm, ".n_reads"}, 64'(got_rd.size()), 64'(exp_rd.size()));
        check({nm, ".n_writes"}, 64'(got_wa.size()), 64'(exp_wa.size()));
        for (int i = 0; i < exp_rd.size() && i < got_rd.size(); i++)
            check($sformatf("%s.rd_addr%0d", nm, i), 64'(got_rd[i]), 64'(exp_rd[i]));
        for (int i = 0; i < exp_wa.size() && i < got_wa.size(); i++) begin
            check($sformatf("%s.wr_addr%0d", nm, i), 64'(got_wa[i]), 64'(exp_wa[i]));
            check($sformatf("%s.wr_data%0d", nm, i), 64'(got_wd[i]), 64'(exp_wd[i]));
        end
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, ".busy"}, 64'(busy_o), 64'd0);
        check({nm, ".done"}, 64'(done_o), 64'd0);
        check({nm, ".error"}, 64'(error_o), 64'd0);
        check({nm, ".count"}, 64'(count_o), 64'd0);
        check({nm, ".bus"}, {26'd0, req_o, we_o, be_o, addr_o}, 64'd0);
        check({nm, ".wdata"}, 64'(wdata_o), 64'd0);
    endtask

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        int          len;
        int          stall;
        bit          extra;
        int          exp_count;
        bit          exp_err;
        int          exp_done;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int len, stall, cnt, dn, req0, dpulse;
        bit extra, err;

        tbl[0] = '{32'h0000_0000, 32'h0000_0100, 4, -1, 1'b0, 4, 1'b0, 13};
        tbl[1] = '{32'h0000_0100, 32'h0000_0200, 0, -1, 1'b0, 0, 1'b0, 1};
        tbl[2] = '{32'hFFFF_FFF8, 32'h0000_0400, 3, -1, 1'b0, 3, 1'b0, 10};
        tbl[3] = '{32'h0000_0000, 32'h0000_0100, 4,  1, 1'b0, 1, 1'b1, 20};
        tbl[4] = '{32'h0000_0003, 32'h0000_0102, 1, -1, 1'b0, 1, 1'b0, 4};
        tbl[5] = '{32'h0000_0040, 32'h0000_0080, 5, -1, 1'b1, 5, 1'b0, 16};
        tbl[6] = '{32'h0000_0200, 32'h0000_0300, 2,  0, 1'b0, 0, 1'b1, 17};
        tbl[7] = '{32'h0000_0010, 32'hFFFF_FFFC, 2, -1, 1'b1, 2, 1'b0, 7};

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check_all_zero("reset");
        rst_i = 1'b0;

        for (int i = 0; i < 8; i++)
            run_copy($sformatf("tbl%0d", i), tbl[i].src, tbl[i].dst, tbl[i].len,
                     tbl[i].stall, tbl[i].extra, tbl[i].exp_count, tbl[i].exp_err,
                     tbl[i].exp_done);

        // Randomized copies; expectations from the per-word timing rules.
        for (int k = 0; k < 20; k++) begin
            len   = int'($urandom_range(0, 6));
            stall = (len > 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            extra = (len > 0) && ($urandom_range(0, 1) == 1);
            err   = (stall >= 0);
            cnt   = err ? stall : len;
            if (len == 0)  dn = 1;
            else if (err)  dn = 3 * stall + TMO + 2;
            else           dn = 3 * len + 1;
            run_copy($sformatf("rnd%0d", k), $urandom, $urandom, len, stall, extra, cnt, err, dn);
        end

        // Reset while waiting for read data: copy abandoned, no done pulse.
        @(posedge clk_i);
        #1;
        stall_rd = -1;
        src_addr_i = 32'h0000_0000;
        dst_addr_i = 32'h0000_0500;
        len_i = 16'd4;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("rstmid.busy_before", 64'(busy_o), 64'd1);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check_all_zero("rstmid");
        req0 = req_total;
        dpulse = 0;
        repeat (20) begin
            @(posedge clk_i);
            #1;
            if (done_o) dpulse++;
        end
        check("rstmid.no_done", 64'(dpulse), 64'd0);
        check("rstmid.no_req", 64'(req_total - req0), 64'd0);
        check_all_zero("rstmid_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
